audio_i2s_tx: RTL and testbench

Downstream consumer of the audio AXI4-Lite slave's sample/control registers. It buffers packed stereo PCM words in a small synchronous FIFO and serialises them as a standard I2S stream (BCLK, LRCLK, SDATA) toward an external DAC. BCLK and LRCLK are generated from ACLK with a programmable divider. Status (FIFO level, sticky underrun) is returned to the slave for software readback.

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_sync_fifo.sv | 65 ++++++
 rtl/audio_i2s_tx.sv | 190 +++++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio transmitter.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int I2S_FRAME_BITS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_state_t;

  typedef struct packed {
    logic [SAMPLE_W_DEFAULT-1:0] left;
    logic [SAMPLE_W_DEFAULT-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rd_data always shows the oldest
// entry, so a pop consumes the word visible in that same cycle.
module audio_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push into a full FIFO is dropped; a pop from an empty one is ignored.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  assign full    = (level_r == LW'(DEPTH));
  assign empty   = (level_r == LW'(0));
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge ACLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: sample FIFO, BCLK divider, frame state machine and
// MSB-first serialiser with the standard one-BCLK data delay after LRCLK.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [2*SAMPLE_W-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          enable,
  input  logic [7:0]                    clk_div,
  input  logic                          underrun_clr,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_W;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] HALF_CNT = BW'(SAMPLE_W);
  localparam logic [BW-1:0] WRAP_CNT = BW'(FRAME_BITS - 1);

  i2s_state_t            state_r;
  i2s_state_t            state_nxt_s;
  logic [7:0]            div_cnt_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [BW-1:0]         bit_nxt_s;
  logic [FRAME_BITS-1:0] shreg_r;
  logic                  bclk_r;
  logic                  lrclk_r;
  logic                  sdata_r;
  logic                  last_r;
  logic                  underrun_r;

  logic                  tc_s;
  logic                  fall_s;
  logic                  wrap_s;
  logic                  start_s;
  logic                  load_s;
  logic                  finish_s;
  logic                  pop_s;
  logic                  ur_set_s;
  logic [FRAME_BITS-1:0] fifo_rd_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  audio_sync_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // >= rather than == so that lowering clk_div mid-count cannot skip the terminal count.
  assign tc_s      = (div_cnt_r >= clk_div);
  assign fall_s    = (state_r != IDLE) && tc_s && bclk_r;
  assign wrap_s    = fall_s && (bit_cnt_r == WRAP_CNT);
  assign bit_nxt_s = bit_cnt_r + BW'(1);
  assign pop_s     = load_s & ~fifo_empty_s;
  assign ur_set_s  = load_s & fifo_empty_s;

  assign s_ready   = ~fifo_full_s;
  assign i2s_bclk  = bclk_r;
  assign i2s_lrclk = lrclk_r;
  assign i2s_sdata = sdata_r;
  assign underrun  = underrun_r;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; STOP leaves for IDLE one terminal count after its final wrap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN: begin
        if (!enable) state_nxt_s = STOP;
        else         state_nxt_s = RUN;
      end
      STOP: begin
        if (enable)              state_nxt_s = RUN;
        else if (last_r && tc_s) state_nxt_s = IDLE;
        else                     state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control strobes: when to load a frame, restart, or finish a stop.
  always_comb begin
    start_s  = 1'b0;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = enable;
        load_s  = enable;
      end
      RUN: begin
        load_s = wrap_s;
      end
      STOP: begin
        if (enable) begin
          // Re-enabled after the final wrap already skipped its load: load now.
          start_s = last_r;
          load_s  = last_r | wrap_s;
        end else begin
          finish_s = last_r & tc_s;
        end
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Divider, bit counter, LRCLK/SDATA generation and the frame shift register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_cnt_r <= 8'd0;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      sdata_r   <= 1'b0;
      last_r    <= 1'b0;
    end else if ((state_r == IDLE) || finish_s) begin
      div_cnt_r <= 8'd0;
      bit_cnt_r <= '0;
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      sdata_r   <= 1'b0;
      last_r    <= 1'b0;
      if (load_s) shreg_r <= pop_s ? fifo_rd_s : '0;
      else        shreg_r <= '0;
    end else begin
      if (tc_s) begin
        div_cnt_r <= 8'd0;
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
      if (fall_s) begin
        sdata_r   <= shreg_r[FRAME_BITS-1];
        bit_cnt_r <= wrap_s ? '0 : bit_nxt_s;
        if (wrap_s)                      lrclk_r <= 1'b0;
        else if (bit_nxt_s == HALF_CNT)  lrclk_r <= 1'b1;
      end
      if (load_s)      shreg_r <= pop_s ? fifo_rd_s : '0;
      else if (fall_s) shreg_r <= shreg_r << 1;
      if (start_s)              last_r <= 1'b0;
      else if (wrap_s && !load_s) last_r <= 1'b1;
    end
  end

  // Sticky underrun flag; a set in the same cycle as a clear wins.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      underrun_r <= 1'b0;
    end else if (ur_set_s) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: reset, single frame, underrun, FIFO full,
// stop mid-frame and asynchronous reset mid-frame.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        enable;
  logic [7:0]  clk_div;
  logic        underrun_clr;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [4:0]  fifo_level;
  logic        underrun;

  int checks   = 0;
  int failures = 0;

  audio_i2s_tx #(
    .FIFO_DEPTH (16),
    .SAMPLE_W   (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .enable       (enable),
    .clk_div      (clk_div),
    .underrun_clr (underrun_clr),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic push_word(input logic [31:0] w);
    s_data  = w;
    s_valid = 1'b1;
    @(negedge ACLK);
    s_valid = 1'b0;
  endtask

  // Wait (bounded) for the next BCLK rising edge and sample SDATA/LRCLK there.
  task automatic next_rise(output logic sd, output logic lr, output int cyc);
    int n;
    n = 0;
    while (i2s_bclk !== 1'b0 && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    while (i2s_bclk !== 1'b1 && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    assert (n < 64) else begin
      failures++;
      $error("FAIL bclk_rise_timeout observed=%0d expected=<64", n);
    end
    sd  = i2s_sdata;
    lr  = i2s_lrclk;
    cyc = n;
  endtask

  // Collect n consecutive BCLK-rise samples, first one ending up most significant.
  task automatic get_bits(input int n, output logic [63:0] sd_v, output logic [63:0] lr_v);
    logic s;
    logic l;
    int   c;
    sd_v = 64'd0;
    lr_v = 64'd0;
    for (int i = 0; i < n; i++) begin
      next_rise(s, l, c);
      sd_v = {sd_v[62:0], s};
      lr_v = {lr_v[62:0], l};
    end
  endtask

  initial begin
    logic           s0, l0, s1, l1, s32, l32;
    int             c, hi_cnt;
    logic [63:0]    v, lv, v2, lv2;
    logic [31:0]    w;
    stereo_sample_t smp;

    // ---------------- reset ----------------
    ARESETN      = 1'b0;
    s_valid      = 1'b1;
    s_data       = 32'hFFFF_FFFF;
    enable       = 1'b0;
    clk_div      = 8'd1;
    underrun_clr = 1'b0;
    wait_cycles(3);
    chk("rst_s_ready",  s_ready,    64'd1);
    chk("rst_level",    fifo_level, 64'd0);
    chk("rst_bclk",     i2s_bclk,   64'd0);
    chk("rst_lrclk",    i2s_lrclk,  64'd0);
    chk("rst_sdata",    i2s_sdata,  64'd0);
    chk("rst_underrun", underrun,   64'd0);
    s_valid = 1'b0;
    ARESETN = 1'b1;
    wait_cycles(10);
    chk("idle_bclk",  i2s_bclk,   64'd0);
    chk("idle_level", fifo_level, 64'd0);

    // ---------------- single frame ----------------
    smp.left  = 16'hA5A5;
    smp.right = 16'h1234;
    push_word(smp);
    chk("push_level", fifo_level, 64'd1);
    enable = 1'b1;
    next_rise(s0, l0, c);
    chk("delay_bit",   s0,         64'd0);
    chk("first_lr",    l0,         64'd0);
    chk("pop_level",   fifo_level, 64'd0);
    next_rise(s1, l1, c);
    chk("bclk_period", c, 64'd4);
    get_bits(30, v, lv);
    chk("frame_no_underrun", underrun, 64'd0);
    next_rise(s32, l32, c);
    chk("frame_sdata",  {s1, v[29:0], s32}, 64'hA5A5_1234);
    chk("frame_lrclk",  {l1, lv[29:0], l32}, 64'h0001_FFFE);

    // ---------------- underrun ----------------
    chk("underrun_set", underrun, 64'd1);
    get_bits(I2S_FRAME_BITS, v, lv);
    chk("underrun_sdata", v,  64'd0);
    chk("underrun_lrclk", lv, 64'h0001_FFFE);
    underrun_clr = 1'b1;
    @(negedge ACLK);
    underrun_clr = 1'b0;
    chk("underrun_clr", underrun, 64'd0);
    get_bits(I2S_FRAME_BITS, v, lv);
    chk("underrun_reset_by_load", underrun, 64'd1);
    enable = 1'b0;
    wait_cycles(200);
    chk("stopped_bclk", i2s_bclk, 64'd0);
    underrun_clr = 1'b1;
    @(negedge ACLK);
    underrun_clr = 1'b0;
    chk("idle_underrun_clr", underrun, 64'd0);

    // ---------------- FIFO full / ordering ----------------
    for (int i = 0; i < 16; i++) begin
      push_word({16'h1000 + 16'(i), 16'hE000 + 16'(i)});
    end
    chk("full_s_ready", s_ready,    64'd0);
    chk("full_level",   fifo_level, 64'd16);
    push_word(32'hDEAD_BEEF);
    chk("drop_level",   fifo_level, 64'd16);
    enable = 1'b1;
    next_rise(s0, l0, c);
    for (int f = 0; f < 16; f++) begin
      get_bits(I2S_FRAME_BITS, v, lv);
      w = {16'h1000 + 16'(f), 16'hE000 + 16'(f)};
      chk($sformatf("fifo_order_%0d", f), v[31:0], w);
    end
    get_bits(I2S_FRAME_BITS, v, lv);
    chk("dropped_word_absent", v,          64'd0);
    chk("drained_level",       fifo_level, 64'd0);
    chk("drained_s_ready",     s_ready,    64'd1);
    chk("drained_underrun",    underrun,   64'd1);
    enable = 1'b0;
    wait_cycles(200);
    underrun_clr = 1'b1;
    @(negedge ACLK);
    underrun_clr = 1'b0;

    // ---------------- stop mid-frame ----------------
    push_word(32'h5A5A_C3C3);
    push_word(32'h0F0F_F0F0);
    chk("stop_pre_level", fifo_level, 64'd2);
    enable = 1'b1;
    next_rise(s0, l0, c);
    chk("stop_one_pop", fifo_level, 64'd1);
    get_bits(5, v, lv);
    enable = 1'b0;
    get_bits(26, v2, lv2);
    chk("stop_frame_sdata", {v[4:0], v2[25:0]}, 64'h2D2D_61E1);
    chk("stop_frame_lrclk", lv2[25:0], 64'h0000_FFFF);
    wait_cycles(20);
    chk("stop_idle_bclk",  i2s_bclk,   64'd0);
    chk("stop_idle_lrclk", i2s_lrclk,  64'd0);
    chk("stop_idle_sdata", i2s_sdata,  64'd0);
    chk("stop_level",      fifo_level, 64'd1);
    chk("stop_underrun",   underrun,   64'd0);
    hi_cnt = 0;
    repeat (40) begin
      @(negedge ACLK);
      if (i2s_bclk) hi_cnt++;
    end
    chk("stop_bclk_quiet", hi_cnt, 64'd0);

    // ---------------- async reset mid-frame ----------------
    push_word(32'h1357_9BDF);
    chk("ar_pre_level", fifo_level, 64'd2);
    enable = 1'b1;
    next_rise(s0, l0, c);
    get_bits(20, v, lv);
    chk("ar_lrclk_high", i2s_lrclk, 64'd1);
    #3;
    ARESETN = 1'b0;
    #1;
    chk("ar_bclk",    i2s_bclk,   64'd0);
    chk("ar_lrclk",   i2s_lrclk,  64'd0);
    chk("ar_sdata",   i2s_sdata,  64'd0);
    chk("ar_level",   fifo_level, 64'd0);
    chk("ar_s_ready", s_ready,    64'd1);
    enable = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    wait_cycles(5);
    chk("ar_post_level", fifo_level, 64'd0);
    chk("ar_post_bclk",  i2s_bclk,   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
